// File: rtl/alu_ctrl_pipe.sv
// rtl/alu_ctrl_pipe.sv - opcode-to-control-word decode table with two-stage stallable pipeline
module alu_ctrl_pipe #(
  parameter int                OP_W        = 5,
  parameter int                CTRL_W      = 26,
  parameter logic [CTRL_W-1:0] APPROX_MASK = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [OP_W-1:0]   cfg_addr,
  input  logic [CTRL_W-1:0] cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_err,
  output logic [15:0]       decode_cnt
);

  localparam int DEPTH = 1 << OP_W;

  localparam logic [1:0] MODE_APPROX  = 2'd1;
  localparam logic [1:0] MODE_NOP     = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  logic [CTRL_W-1:0] tbl [DEPTH];

  logic              en;
  logic              s1_valid;
  logic [CTRL_W-1:0] s1_word;
  logic [1:0]        s1_mode;
  logic [CTRL_W-1:0] s2_word;
  logic              s2_err;

  // Both stages move together; a held output freezes the whole pipe.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Decode table: writes land at the edge, so a same-cycle S1 read sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Stage 1: capture the table entry at acceptance so later writes cannot alter it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_mode  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_word  <= tbl[in_op];
      s1_mode  <= in_mode;
    end
  end

  // Mode shaping of the captured word; bubbles carry an all-zero word.
  always_comb begin
    s2_word = s1_word;
    s2_err  = 1'b0;
    case (s1_mode)
      MODE_APPROX:  s2_word = s1_word & ~APPROX_MASK;
      MODE_NOP:     s2_word = '0;
      MODE_ILLEGAL: s2_err  = 1'b1;
      default:      ;
    endcase
    if (!s1_valid) begin
      s2_word = '0;
      s2_err  = 1'b0;
    end
  end

  // Stage 2: output registers, the only source of out_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_err   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_ctrl  <= s2_word;
      out_err   <= s2_err;
    end
  end

  // Saturating count of completed output transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      decode_cnt <= '0;
    end else if (out_valid && out_ready && (decode_cnt != 16'hFFFF)) begin
      decode_cnt <= decode_cnt + 16'd1;
    end
  end

endmodule

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 Parameter OP_W, default 5, opcode width; decode table depth = 2**OP_W entries.
REQ-002 Parameter CTRL_W, default 26, control-word width (one bit per ALU control line).
REQ-003 Parameter APPROX_MASK, default {CTRL_W{1'b0}}, bits forced to 0 in approximate mode.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_we  input  1  table write strobe.
REQ-007 cfg_addr  input  OP_W  table entry to write.
REQ-008 cfg_data  input  CTRL_W  control word to store.
REQ-009 in_valid  input  1  opcode request valid.
REQ-010 in_ready  output  1  request accepted when in_valid & in_ready.
REQ-011 in_op  input  OP_W  opcode (table index).
REQ-012 in_mode  input  2  0 exact, 1 approximate, 2 nop, 3 illegal.
REQ-013 out_valid  output  1  decoded word valid.
REQ-014 out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-015 out_ctrl  output  CTRL_W  decoded control word.
REQ-016 out_err  output  1  set with the word whose request had in_mode==3.
REQ-017 decode_cnt  output  16  count of completed output transfers.

Function
REQ-018 Table: 2**OP_W x CTRL_W registers; cfg_we writes cfg_data to entry cfg_addr at clock edge; writes accepted every cycle regardless of pipeline state.
REQ-019 Pipeline: two stages; S1 registers table[in_op], in_mode, valid; S2 registers masked word, err, valid; out_* driven from S2 registers only.
REQ-020 Latency: accepted request appears on out_* exactly 2 cycles after acceptance when out_ready held high.
REQ-021 Global advance en = !out_valid | out_ready; in_ready = en; S1 and S2 both load only when en=1.
REQ-022 Stall: while en=0, S1/S2 contents, out_ctrl, out_err, out_valid hold stable; no request lost or duplicated.
REQ-023 Bubbles are not collapsed; an empty S1 advancing produces out_valid=0 in S2.
REQ-024 Throughput: one request per cycle when out_ready held high.
REQ-025 Mode 0: out_ctrl = entry; mode 1: out_ctrl = entry & ~APPROX_MASK; mode 2: out_ctrl = 0; mode 3: out_ctrl = entry, out_err=1.
REQ-026 out_err = 0 for modes 0-2.
REQ-027 Write/read collision: cfg write and S1 read of same entry in same cycle returns the old contents; new contents visible from the next cycle.
REQ-028 Table entry captured at S1 load; later writes to that entry do not alter an in-flight word.
REQ-029 decode_cnt increments by 1 on each cycle with out_valid & out_ready; saturates at 16'hFFFF, no wrap.
REQ-030 in_op used as full OP_W index; no out-of-range case exists.

Reset
REQ-031 rst=1 at a clock edge: all table entries 0, S1/S2 valid 0, out_valid 0, out_ctrl 0, out_err 0, decode_cnt 0.
REQ-032 in_ready = 1 in the first cycle after reset deasserts (pipeline empty).
REQ-033 Reset asserted mid-operation discards all in-flight requests; no output transfer occurs in the reset cycle; cfg writes in the reset cycle are ignored.

Verification
REQ-034 Write entry 3 = 26'h2AAAAAA, send op=3 mode=0 with out_ready=1 -> out_valid at cycle+2, out_ctrl=26'h2AAAAAA, out_err=0, decode_cnt=1.
REQ-035 APPROX_MASK=26'h00000FF, entry 5 = 26'h3FFFFFF, op=5 mode=1 -> out_ctrl=26'h3FFFF00; same op mode=2 -> 0; mode=3 -> 26'h3FFFFFF with out_err=1.
REQ-036 Stream ops 0..7 back-to-back, out_ready low 3 cycles mid-stream -> out_valid/out_ctrl held stable during stall, in_ready=0 while stalled, all 8 words delivered in order, decode_cnt=8.
REQ-037 Same cycle: cfg write entry 4 old=26'h1 -> new=26'h2 and accept op=4 -> returns 26'h1; op=4 next cycle -> 26'h2.
REQ-038 Preload decode_cnt to saturation via 65540 transfers -> holds 16'hFFFF.
REQ-039 Assert rst with two requests in flight -> next cycle out_valid=0, out_ctrl=0, decode_cnt=0, all entries read back 0.
